// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the gate_bist cell self-test block.
// Latency: n/a (types, constants and a combinational MISR helper only).
// Backpressure: n/a.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEF_POLY  = 8'h1D;
    localparam logic [7:0] DEF_SEED  = 8'h00;

    // Widest signature the helper below can handle; callers zero-extend.
    localparam int SIG_W_MAX = 32;

    // One bit of the next MISR value: shift left, fold the outgoing MSB back
    // through the polynomial, and inject the sampled response into bit 0.
    function automatic logic misr_bit(
        input logic [SIG_W_MAX-1:0] sig,
        input logic [SIG_W_MAX-1:0] poly,
        input logic [4:0]           msb_idx,
        input logic [4:0]           idx,
        input logic                 din
    );
        logic b;
        b = sig[msb_idx] & poly[idx];
        if (idx == 5'd0) begin
            b = b ^ din;
        end else begin
            b = b ^ sig[idx - 5'd1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// Signature register: loads the seed on load, folds din in on en (load wins).
// Latency: sig reflects load/en one cycle after the sampling edge.
// Backpressure: none; en is taken every cycle it is high.
// Ports: CLK, R (async active-low), load, en, din -> sig[SIG_W-1:0].
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0]     sig_q;
    logic [SIG_W-1:0]     sig_d;
    logic [SIG_W-1:0]     step;
    logic [SIG_W_MAX-1:0] sig_ext;
    logic [SIG_W_MAX-1:0] poly_ext;

    always_comb begin
        sig_ext               = '0;
        sig_ext[SIG_W-1:0]    = sig_q;
        poly_ext              = '0;
        poly_ext[SIG_W-1:0]   = POLY;
        step                  = '0;
        for (int i = 0; i < SIG_W; i++) begin
            step[i] = misr_bit(sig_ext, poly_ext, 5'(SIG_W - 1), 5'(i), din);
        end
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = step;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/gate_bist.sv
// Exhaustive Gray-order stimulus driver for a combinational cell plus MISR compare.
// Latency: 2^N_IN*SETTLE cycles from START to DONE/PASS; VEC valid the cycle after START.
// Backpressure: none; START is ignored while a run is in progress.
// Ports: CLK, R (async active-low), START, Y, SIG_EXP -> VEC, BUSY, DONE, PASS, SIG.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int               N_IN   = 3,
    parameter int               SETTLE = 2,
    parameter int               SIG_W  = 8,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic             Y,
    input  logic [SIG_W-1:0] SIG_EXP,
    output logic [N_IN-1:0]  VEC,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    localparam int              HC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(SETTLE - 1);

    state_e               state_q, state_d;
    logic [N_IN-1:0]      cnt_q, cnt_d;
    logic [HC_W-1:0]      hc_q, hc_d;
    logic                 pass_q, pass_d;
    logic                 load;
    logic                 sample;
    logic [SIG_W-1:0]     sig_next;
    logic [SIG_W_MAX-1:0] sig_ext;
    logic [SIG_W_MAX-1:0] poly_ext;

    // Value the MISR will hold after this cycle's sample; needed so the final
    // compare sees the signature including the last response bit.
    always_comb begin
        sig_ext             = '0;
        sig_ext[SIG_W-1:0]  = SIG;
        poly_ext            = '0;
        poly_ext[SIG_W-1:0] = POLY;
        sig_next            = '0;
        for (int i = 0; i < SIG_W; i++) begin
            sig_next[i] = misr_bit(sig_ext, poly_ext, 5'(SIG_W - 1), 5'(i), Y);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hc_d    = hc_q;
        pass_d  = pass_q;
        load    = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    hc_d    = '0;
                    pass_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (hc_q == HC_LAST) begin
                    sample = 1'b1;
                    hc_d   = '0;
                    cnt_d  = cnt_q + 1'b1;  // wraps to 0 after the last vector
                    if (cnt_q == '1) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next == SIG_EXP);
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hc_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hc_q    <= hc_d;
            pass_q  <= pass_d;
        end
    end

    gate_bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CLK  (CLK),
        .R    (R),
        .load (load),
        .en   (sample),
        .din  (Y),
        .sig  (SIG)
    );

    // Gray encode so consecutive vectors differ in exactly one pin.
    assign VEC  = (state_q == ST_RUN) ? (cnt_q ^ (cnt_q >> 1)) : '0;
    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign PASS = pass_q;

endmodule
